// File: rtl/div_result_bcd.sv
// Binary-to-BCD converter for the divider's quotient/remainder pair.
// Runs iterative double dabble one bit per clock and holds the result under valid/ready.
module div_result_bcd #(
  parameter int SIZE   = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE-1:0]       quotient,
  input  logic [SIZE-1:0]       remainder,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   quo_bcd,
  output logic [4*DIGITS-1:0]   rem_bcd,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] quo_bin, rem_bin;
  logic [BW-1:0]   quo_work, rem_work;
  logic [BW+SIZE-1:0] quo_step, rem_step;

  // Per-nibble add-3; each digit is adjusted independently, no carry between nibbles.
  function automatic logic [BW-1:0] adjust(input logic [BW-1:0] bcd);
    logic [BW-1:0] res;
    res = bcd;
    for (int d = 0; d < DIGITS; d++)
      if (bcd[4*d +: 4] >= 4'd5) res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    return res;
  endfunction

  always_comb begin
    quo_step = {adjust(quo_work), quo_bin} << 1;
    rem_step = {adjust(rem_work), rem_bin} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      quo_bin  <= '0;
      rem_bin  <= '0;
      quo_work <= '0;
      rem_work <= '0;
      quo_bcd  <= '0;
      rem_bcd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            quo_bin  <= quotient;
            rem_bin  <= remainder;
            quo_work <= '0;
            rem_work <= '0;
            cnt      <= '0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          {quo_work, quo_bin} <= quo_step;
          {rem_work, rem_bin} <= rem_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quo_bcd <= quo_step[BW+SIZE-1 -: BW];
            rem_bcd <= rem_step[BW+SIZE-1 -: BW];
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode the state register only, so no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CONVERT);

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd: SIZE=4/DIGITS=2 main instance plus a SIZE=8/DIGITS=3 instance.
module tb_div_result_bcd;

  logic       clk, rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] quotient, remainder;
  logic [7:0] quo_bcd, rem_bcd;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, busy_w;
  logic [7:0]  quotient_w, remainder_w;
  logic [11:0] quo_bcd_w, rem_bcd_w;

  int checks = 0;
  int errors = 0;
  logic [23:0] sb[$];
  logic [23:0] sb_w[$];

  div_result_bcd #(.SIZE(4), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .remainder(remainder), .out_valid(out_valid),
    .out_ready(out_ready), .quo_bcd(quo_bcd), .rem_bcd(rem_bcd), .busy(busy)
  );

  div_result_bcd #(.SIZE(8), .DIGITS(3)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .quotient(quotient_w), .remainder(remainder_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .quo_bcd(quo_bcd_w), .rem_bcd(rem_bcd_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion by decimal division, independent of the shift-and-add algorithm.
  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic start(input logic [3:0] q, input logic [3:0] r);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: in_ready=%b, required 1", in_ready);
    end
    quotient  = q;
    remainder = r;
    in_valid  = 1'b1;
    sb.push_back({to_bcd(int'(q)), to_bcd(int'(r))});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int n;
    logic [23:0] e;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
    end else begin
      checks++;
      if (n !== exp_lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s_scoreboard: result with no expected entry", name);
      end else begin
        e = sb.pop_front();
        if (quo_bcd !== e[19:12] || rem_bcd !== e[7:0]) begin
          errors++;
          $display("FAIL %s_value: quo_bcd=%h rem_bcd=%h, required %h %h",
                   name, quo_bcd, rem_bcd, e[19:12], e[7:0]);
        end
      end
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        quo_bcd !== 8'h00 || rem_bcd !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b quo=%h rem=%h, required 1 0 0 00 00",
               in_ready, out_valid, busy, quo_bcd, rem_bcd);
    end
    checks++;
    if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0 || quo_bcd_w !== 12'h000) begin
      errors++;
      $display("FAIL reset_wide: in_ready=%b out_valid=%b quo=%h, required 1 0 000",
               in_ready_w, out_valid_w, quo_bcd_w);
    end
  endtask

  task automatic test_basic;
    start(4'd13, 4'd9);  wait_result("pair_13_9", 5);  release_out("pair_13_9");
    start(4'd15, 4'd0);  wait_result("pair_15_0", 5);  release_out("pair_15_0");
    start(4'd0, 4'd0);   wait_result("pair_0_0", 5);   release_out("pair_0_0");
    start(4'd15, 4'd15); wait_result("pair_15_15", 5); release_out("pair_15_15");
  endtask

  task automatic test_wide;
    int n;
    logic [23:0] e;
    quotient_w  = 8'd255;
    remainder_w = 8'd100;
    in_valid_w  = 1'b1;
    sb_w.push_back({to_bcd(255), to_bcd(100)});
    @(negedge clk);
    in_valid_w = 1'b0;
    n = 1;
    while (!out_valid_w && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid_w !== 1'b1 || n !== 9) begin
      errors++;
      $display("FAIL wide_latency: out_valid=%b after %0d cycles, required 1 after 9", out_valid_w, n);
    end
    e = sb_w.pop_front();
    checks++;
    if (quo_bcd_w !== e[23:12] || rem_bcd_w !== e[11:0]) begin
      errors++;
      $display("FAIL wide_value: quo_bcd=%h rem_bcd=%h, required %h %h",
               quo_bcd_w, rem_bcd_w, e[23:12], e[11:0]);
    end
    out_ready_w = 1'b1;
    @(negedge clk);
    out_ready_w = 1'b0;
    checks++;
    if (out_valid_w !== 1'b0 || in_ready_w !== 1'b1) begin
      errors++;
      $display("FAIL wide_release: out_valid=%b in_ready=%b, required 0 1", out_valid_w, in_ready_w);
    end
  endtask

  task automatic test_back_pressure;
    start(4'd13, 4'd9);
    wait_result("bp_first", 5);
    for (int i = 0; i < 5; i++) begin
      quotient  = 4'd7;
      remainder = 4'd3;
      in_valid  = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quo_bcd !== 8'h13 || rem_bcd !== 8'h09) begin
        errors++;
        $display("FAIL bp_hold: out_valid=%b in_ready=%b quo=%h rem=%h, required 1 0 13 09",
                 out_valid, in_ready, quo_bcd, rem_bcd);
      end
    end
    in_valid = 1'b0;
    release_out("bp_first");
    start(4'd7, 4'd3);
    wait_result("bp_second", 5);
    release_out("bp_second");
  endtask

  task automatic test_reset_mid_convert;
    start(4'd5, 4'd6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        quo_bcd !== 8'h00 || rem_bcd !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b quo=%h rem=%h, required 1 0 0 00 00",
               in_ready, out_valid, busy, quo_bcd, rem_bcd);
    end
    start(4'd9, 4'd2);
    wait_result("after_reset", 5);
    release_out("after_reset");
  endtask

  task automatic test_back_to_back;
    int last_acc, busy_cnt;
    bit acc_prev;
    logic [3:0] q, r;
    logic [23:0] e;
    q = 4'd1; r = 4'd2;
    quotient = q; remainder = r;
    in_valid = 1'b1; out_ready = 1'b1;
    last_acc = -1; busy_cnt = 0; acc_prev = 1'b0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (acc_prev) begin
        q = q + 4'd3; r = r + 4'd5;
        quotient = q; remainder = r;
        acc_prev = 1'b0;
      end
      if (cyc == 40) in_valid = 1'b0;
      if (busy) busy_cnt++;
      if (out_valid) begin
        checks++;
        if (busy_cnt !== 4) begin
          errors++;
          $display("FAIL b2b_busy: busy high %0d cycles, required 4", busy_cnt);
        end
        busy_cnt = 0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_scoreboard: result with no expected entry");
        end else begin
          e = sb.pop_front();
          if (quo_bcd !== e[19:12] || rem_bcd !== e[7:0]) begin
            errors++;
            $display("FAIL b2b_value: quo_bcd=%h rem_bcd=%h, required %h %h",
                     quo_bcd, rem_bcd, e[19:12], e[7:0]);
          end
        end
      end
      if (in_ready && in_valid) begin
        sb.push_back({to_bcd(int'(q)), to_bcd(int'(r))});
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 6) begin
            errors++;
            $display("FAIL b2b_interval: accept gap %0d cycles, required 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        acc_prev = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; quotient = '0; remainder = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; quotient_w = '0; remainder_w = '0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_wide;
    test_back_pressure;
    test_reset_mid_convert;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
